// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM state type and FIFO entry type for the fetch front end.
//   XLEN/ILEN fix the PC and instruction widths used by fetch_fifo and fetch_queue_unit.
package fetch_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int INST_BYTES = 4;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} fetch_state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: QDEPTH-entry circular buffer of fetched {pc,inst} pairs with synchronous flush.
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   push_i, data_i    write data_i at the tail
//   pop_i             drop the head entry
//   flush_i           empty the buffer and return both pointers to 0 (overrides push/pop)
//   count_o, head_o   occupancy and registered head entry
// Callers never push when full nor pop when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  QDEPTH  = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  entry_t                  data_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  output logic [$clog2(QDEPTH):0] count_o,
  output entry_t                  head_o
);
  localparam int AW = $clog2(QDEPTH);
  entry_t mem_q [QDEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: PC generation and decoupled instruction fetch between icache and ID.
//   clk_i, rst_ni                    clock, asynchronous active-low reset (pc loads entry_i)
//   entry_i                          start PC
//   ic_req_valid_o/addr_o/ready_i    single-outstanding icache request
//   ic_resp_valid_i/inst_i           one-cycle response pulse
//   redirect_valid_i/pc_i            NREDIR redirect channels, index 0 has priority
//   id_valid_o/pc_o/inst_o/ready_i   FIFO head towards ID
//   halt_o                           sticky, set DRAIN_CYCLES after a zero instruction is consumed
//   misalign_err_o                   sticky misaligned-redirect flag
// Optional feature macro: FETCHQ_MISALIGN_CHK_EN (misaligned redirect detection, target
// forced to word alignment). Without it misalign_err_o is 0 and targets are used as given.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int QDEPTH       = 4,
  parameter int NREDIR       = 2,
  parameter int DRAIN_CYCLES = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [XLEN-1:0]        entry_i,
  output logic                   ic_req_valid_o,
  output logic [XLEN-1:0]        ic_req_addr_o,
  input  logic                   ic_req_ready_i,
  input  logic                   ic_resp_valid_i,
  input  logic [ILEN-1:0]        ic_resp_inst_i,
  input  logic [NREDIR-1:0]      redirect_valid_i,
  input  logic [NREDIR*XLEN-1:0] redirect_pc_i,
  output logic                   id_valid_o,
  output logic [XLEN-1:0]        id_pc_o,
  output logic [ILEN-1:0]        id_inst_o,
  input  logic                   id_ready_i,
  output logic                   halt_o,
  output logic                   misalign_err_o
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  fetch_state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, redir_pc, redir_tgt;
  logic [DW-1:0] drain_q, drain_d;
  logic [CW-1:0] count;
  logic epoch_q, req_epoch_q, out_q;
  logic redir, issue, resp, push, pop;
  fetch_entry_t head, push_data;
  // Scan from the lowest priority channel up so the lowest set index overwrites the rest.
  always_comb begin
    redir_pc = '0;
    for (int i = NREDIR - 1; i >= 0; i--)
      if (redirect_valid_i[i]) redir_pc = redirect_pc_i[i*XLEN +: XLEN];
  end
  assign redir = |redirect_valid_i && state_q != HALTED;
`ifdef FETCHQ_MISALIGN_CHK_EN
  logic mis_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mis_q <= 1'b0;
    else if (redir && |redir_pc[1:0]) mis_q <= 1'b1;
  end
  assign misalign_err_o = mis_q;
  assign redir_tgt = {redir_pc[XLEN-1:2], 2'b00};
`else
  assign misalign_err_o = 1'b0;
  assign redir_tgt = redir_pc;
`endif
  // Issue is held off while any redirect is raised so a stale PC never reaches the icache.
  assign ic_req_valid_o = rst_ni && state_q == RUN && !out_q && count != CW'(QDEPTH) && !(|redirect_valid_i);
  assign ic_req_addr_o  = rst_ni ? pc_q : entry_i;
  assign issue      = ic_req_valid_o && ic_req_ready_i;
  assign resp       = ic_resp_valid_i && out_q;
  assign push       = resp && req_epoch_q == epoch_q && !redir;
  assign id_valid_o = count != '0;
  assign pop        = id_valid_o && id_ready_i && !redir;
  assign push_data  = '{pc: req_pc_q, inst: ic_resp_inst_i};
  assign pc_d       = redir ? redir_tgt : issue ? pc_q + XLEN'(INST_BYTES) : pc_q;
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    if (state_q == RUN && pop && head.inst == '0) begin
      state_d = DRAIN;
      drain_d = '0;
    end else if (state_q == DRAIN) begin
      if (redir) begin
        state_d = RUN;
        drain_d = '0;
      end else if (drain_q == DW'(DRAIN_CYCLES - 1)) state_d = HALTED;
      else drain_d = drain_q + DW'(1);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      drain_q     <= '0;
      pc_q        <= entry_i;
      epoch_q     <= 1'b0;
      out_q       <= 1'b0;
      req_pc_q    <= '0;
      req_epoch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_q ^ redir;
      out_q   <= issue | (out_q & !resp);
      if (issue) begin
        req_pc_q    <= pc_q;
        req_epoch_q <= epoch_q;
      end
    end
  end
  fetch_fifo #(.QDEPTH(QDEPTH), .entry_t(fetch_entry_t)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .data_i (push_data),
    .pop_i  (pop),
    .flush_i(redir),
    .count_o(count),
    .head_o (head)
  );
  assign id_pc_o   = head.pc;
  assign id_inst_o = head.inst;
  assign halt_o    = state_q == HALTED;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: randomized scoreboard bench plus directed scenarios for fetch_queue_unit.
module tb_fetch_queue_unit;
  logic clk = 1'b0;
  logic rst_n, ic_req_valid, ic_req_ready, ic_resp_valid, id_valid, id_ready, halt, misalign_err;
  logic [63:0] entry, ic_req_addr, id_pc;
  logic [31:0] ic_resp_inst, id_inst;
  logic [1:0] redirect_valid;
  logic [127:0] redirect_pc;
  always #5 clk = ~clk;
  fetch_queue_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .entry_i(entry),
    .ic_req_valid_o(ic_req_valid), .ic_req_addr_o(ic_req_addr), .ic_req_ready_i(ic_req_ready),
    .ic_resp_valid_i(ic_resp_valid), .ic_resp_inst_i(ic_resp_inst),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .id_valid_o(id_valid), .id_pc_o(id_pc), .id_inst_o(id_inst), .id_ready_i(id_ready),
    .halt_o(halt), .misalign_err_o(misalign_err)
  );
  int errs = 0, checks = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Scoreboard model: expected FIFO contents, outstanding request and redirect generation.
  typedef struct { logic [63:0] pc; logic [31:0] inst; } ent_t;
  ent_t sb[$];
  bit model_on = 0, pend = 0;
  int gen = 0, pgen = 0, exp_cnt = 0;
  logic [63:0] paddr, pcm;
  task automatic rand_cycle();
    logic [63:0] tgt;
    ic_req_ready   = $urandom_range(0, 3) != 0;
    id_ready       = $urandom_range(0, 2) != 0;
    redirect_valid = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    redirect_pc    = {64'h2000 + 64'($urandom_range(0, 255)) * 4, 64'h3000 + 64'($urandom_range(0, 255)) * 4};
    ic_resp_valid  = pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
    ic_resp_inst   = $urandom | 32'h1;
    @(negedge clk);
    exp_cnt = sb.size();
    chk("req_valid", ic_req_valid, !pend && redirect_valid == 0 && sb.size() < 4);
    if (redirect_valid != 0) begin
      sb.delete();
      gen++;
      tgt = redirect_valid[0] ? redirect_pc[63:0] : redirect_pc[127:64];
      pcm = tgt;
    end else if (ic_resp_valid && pend && pgen % 2 == gen % 2) sb.push_back('{paddr, ic_resp_inst});
    if (ic_resp_valid && pend) pend = 0;
    if (ic_req_valid && ic_req_ready) begin
      chk("req_addr", ic_req_addr, pcm);
      pend = 1;
      paddr = pcm;
      pgen = gen;
      pcm = pcm + 4;
    end
    @(posedge clk);
    #1;
  endtask
  always begin
    @(negedge clk);
    #1;
    if (model_on) begin
      chk("id_valid", id_valid, exp_cnt != 0);
      if (id_valid && id_ready && redirect_valid == 0) begin
        if (sb.size() == 0) chk("pop_empty_sb", 1, 0);
        else begin
          chk("id_pc", id_pc, sb[0].pc);
          chk("id_inst", id_inst, sb[0].inst);
          void'(sb.pop_front());
        end
      end
    end
  end
  // Directed icache responder: answers each accepted request lat steps later.
  int lat = 1, rcnt = 0;
  logic [63:0] raddr = 0, zaddr = '1;
  logic [63:0] req_log[$], pop_log[$];
  bit zpop = 0;
  function automatic logic [31:0] fi(logic [63:0] a);
    return (a == zaddr) ? 32'h0 : {a[31:2], 2'b11};
  endfunction
  task automatic step();
    ic_resp_valid = rcnt == 1;
    ic_resp_inst  = fi(raddr);
    if (rcnt > 0) rcnt--;
    @(negedge clk);
    zpop = 0;
    if (ic_req_valid && ic_req_ready) begin
      req_log.push_back(ic_req_addr);
      raddr = ic_req_addr;
      rcnt = lat;
    end
    if (id_valid && id_ready && redirect_valid == 0) begin
      pop_log.push_back(id_pc);
      zpop = id_inst == 0;
    end
    @(posedge clk);
    #1;
    ic_resp_valid = 0;
    redirect_valid = 0;
  endtask
  task automatic step_until_zpop(string nm);
    int n = 0;
    zpop = 0;
    while (!zpop && n < 40) begin
      step();
      n++;
    end
    chk(nm, zpop, 1);
  endtask
  task automatic reset_dut(logic [63:0] v, bit keep);
    rst_n = 0;
    entry = v;
    ic_req_ready = 0;
    id_ready = 0;
    redirect_valid = 0;
    ic_resp_valid = 0;
    if (!keep) rcnt = 0;
    #2;
    chk("rst_req_valid", ic_req_valid, 0);
    chk("rst_req_addr", ic_req_addr, v);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_halt", halt, 0);
    chk("rst_misalign", misalign_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    req_log.delete();
    pop_log.delete();
    zpop = 0;
  endtask
  logic [63:0] mtgt, mexp;
  bit mis_exp;
  int k;
  initial begin
    rst_n = 1; entry = 0; ic_req_ready = 0; ic_resp_valid = 0; ic_resp_inst = 0;
    redirect_valid = 0; redirect_pc = 0; id_ready = 0;
`ifdef FETCHQ_MISALIGN_CHK_EN
    mtgt = 64'h2002; mexp = 64'h2000; mis_exp = 1;
`else
    mtgt = 64'h2000; mexp = 64'h2000; mis_exp = 0;
`endif
    #1;
    reset_dut(64'h8000, 0);
    pcm = 64'h8000;
    model_on = 1;
    repeat (800) rand_cycle();
    model_on = 0;
    ic_resp_valid = 0;
    redirect_valid = 0;
    // In-order fetch stream
    reset_dut(64'h1000, 0);
    ic_req_ready = 1; id_ready = 1; lat = 1;
    repeat (10) step();
    chk("t1_npops", pop_log.size() >= 3, 1);
    if (pop_log.size() >= 3) begin
      chk("t1_pc0", pop_log[0], 64'h1000);
      chk("t1_pc1", pop_log[1], 64'h1004);
      chk("t1_pc2", pop_log[2], 64'h1008);
    end
    // Full FIFO back-pressure
    reset_dut(64'h1000, 0);
    ic_req_ready = 1; lat = 1;
    repeat (16) step();
    chk("t2_nreq_full", req_log.size(), 4);
    chk("t2_req_valid_full", ic_req_valid, 0);
    id_ready = 1;
    step();
    id_ready = 0;
    repeat (6) step();
    chk("t2_nreq_after_pop", req_log.size(), 5);
    if (req_log.size() == 5) chk("t2_addr5", req_log[4], 64'h1010);
    // Redirect with an in-flight request, then priority between channels
    reset_dut(64'h1000, 0);
    ic_req_ready = 1; lat = 1; k = 0;
    while (req_log.size() < 3 && k < 20) begin
      if (req_log.size() == 2) lat = 3;
      step();
      k++;
    end
    chk("t3_third_req", req_log.size() == 3 ? req_log[2] : 64'h0, 64'h1008);
    lat = 1;
    redirect_valid = 2'b10;
    redirect_pc = {64'h2000, 64'h0};
    step();
    pop_log.delete();
    chk("t3_flushed", id_valid, 0);
    chk("t3_pc", ic_req_addr, 64'h2000);
    id_ready = 1;
    repeat (10) step();
    chk("t3_first_pop", pop_log.size() > 0 ? pop_log[0] : 64'h0, 64'h2000);
    redirect_valid = 2'b11;
    redirect_pc = {64'h2000, 64'h3000};
    step();
    chk("t4_prio", ic_req_addr, 64'h3000);
    // Zero instruction drain and halt
    reset_dut(64'h1000, 0);
    ic_req_ready = 1; id_ready = 1; lat = 1; zaddr = 64'h100C;
    step_until_zpop("t5_zero_pop");
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) step();
      chk($sformatf("t5_halt_%0d", i), halt, i == 5);
      if (i < 5) chk($sformatf("t5_noissue_%0d", i), ic_req_valid, 0);
    end
    redirect_valid = 2'b01;
    redirect_pc = {64'h0, 64'h5000};
    step();
    chk("t5_halt_sticky", halt, 1);
    chk("t5_redir_ignored", ic_req_addr == 64'h5000, 0);
    // Redirect mid-drain, optional misalignment, reset mid-drain
    reset_dut(64'h1000, 0);
    ic_req_ready = 1; id_ready = 1; lat = 1; zaddr = 64'h100C;
    step_until_zpop("t6_zero_pop");
    repeat (2) step();
    redirect_valid = 2'b01;
    redirect_pc = {64'h0, mtgt};
    step();
    chk("t6_misalign", misalign_err, mis_exp);
    chk("t6_tgt", ic_req_addr, mexp);
    k = req_log.size();
    zaddr = 64'h2008;
    step_until_zpop("t6_second_zero");
    chk("t6_resume_addr", req_log.size() > k ? req_log[k] : 64'h0, mexp);
    chk("t6_no_halt", halt, 0);
    step();
    reset_dut(64'h1000, 0);
    // Reset while a request is outstanding
    ic_req_ready = 1; lat = 3; zaddr = '1;
    step();
    chk("t7_accepted", req_log.size(), 1);
    reset_dut(64'h1000, 1);
    repeat (4) step();
    chk("t7_resp_ignored", id_valid, 0);
    chk("t7_out_cleared", ic_req_valid, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
